// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx
//   Bit-serial to byte-parallel receiver for the lane link. The serial stream
//   arrives MSB first, one bit per rising edge of clk_32f. The receiver finds
//   byte alignment by hunting for COM symbols. It declares the link active once
//   N_COM consecutive aligned COMs have been seen. After that it delivers data
//   bytes as byte-rate levels.
//
// Ports
//   clk_32f   in   bit clock (rising edge)
//   reset     in   synchronous, active-high
//   data_in   in   serial bit, MSB of each byte first
//   data_out  out  [7:0] last received data byte
//   valid_out out  data_out holds a data byte for this byte period
//   byte_stb  out  one-cycle pulse on each byte boundary while aligned
//   active    out  link aligned and up
//   idle_out  out  link active and last received byte was IDL
//
// state      | meaning
// -----------+---------------------------------------------------------------
// UNALIGNED  | bit-by-bit search for COM, all outputs 0
// ALIGNING   | byte-locked, counting consecutive boundary-aligned COMs
// ACTIVE     | link up, delivering data bytes (left only by reset)

module serial_paralelo_rx #(
    parameter logic [7:0] COM   = 8'hBC,
    parameter logic [7:0] IDL   = 8'h7C,
    parameter int         N_COM = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_stb,
    output logic       active,
    output logic       idle_out
);

    localparam int CW = $clog2(N_COM + 1);

    typedef enum logic [1:0] {
        ST_UNALIGNED = 2'd0,
        ST_ALIGNING  = 2'd1,
        ST_ACTIVE    = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [7:0]      sr;
    logic [2:0]      bit_cnt, bit_cnt_d;
    logic [CW-1:0]   com_cnt, com_cnt_d;
    logic [CW-1:0]   com_inc;
    logic [7:0]      nxt;
    logic            boundary;
    logic [7:0]      data_d;
    logic            valid_d, stb_d, active_d, idle_d;

    // nxt is the byte that includes the bit being sampled on this edge.
    assign nxt      = {sr[6:0], data_in};
    assign boundary = (bit_cnt == 3'd7);
    assign com_inc  = com_cnt + 1'b1;

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt + 3'd1;
        com_cnt_d = com_cnt;
        data_d    = data_out;
        valid_d   = valid_out;
        idle_d    = idle_out;
        active_d  = active;
        stb_d     = 1'b0;

        case (state)
            ST_UNALIGNED: begin
                bit_cnt_d = 3'd0;
                com_cnt_d = '0;
                data_d    = 8'h00;
                valid_d   = 1'b0;
                idle_d    = 1'b0;
                active_d  = 1'b0;
                if (nxt == COM) begin
                    com_cnt_d = CW'(1);
                    if (N_COM <= 1) begin
                        state_d  = ST_ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ST_ALIGNING;
                    end
                end
            end

            ST_ALIGNING: begin
                if (boundary) begin
                    stb_d = 1'b1;
                    if (nxt == COM) begin
                        com_cnt_d = com_inc;
                        if (com_inc == CW'(N_COM)) begin
                            state_d  = ST_ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        // Misaligned or corrupted lock: restart the bit search.
                        // sr keeps shifting, so a COM straddling this byte can still be found.
                        state_d   = ST_UNALIGNED;
                        com_cnt_d = '0;
                        bit_cnt_d = 3'd0;
                    end
                end
            end

            ST_ACTIVE: begin
                active_d = 1'b1;
                if (boundary) begin
                    stb_d = 1'b1;
                    if (nxt == COM || nxt == IDL) begin
                        valid_d = 1'b0;
                        idle_d  = (nxt == IDL);
                    end else begin
                        data_d  = nxt;
                        valid_d = 1'b1;
                        idle_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d   = ST_UNALIGNED;
                bit_cnt_d = 3'd0;
                com_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= ST_UNALIGNED;
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
            com_cnt   <= '0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            byte_stb  <= 1'b0;
            active    <= 1'b0;
            idle_out  <= 1'b0;
        end else begin
            state     <= state_d;
            sr        <= nxt;
            bit_cnt   <= bit_cnt_d;
            com_cnt   <= com_cnt_d;
            data_out  <= data_d;
            valid_out <= valid_d;
            byte_stb  <= stb_d;
            active    <= active_d;
            idle_out  <= idle_d;
        end
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
module tb_serial_paralelo_rx;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out, byte_stb, active, idle_out;

    serial_paralelo_rx dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .byte_stb  (byte_stb),
        .active    (active),
        .idle_out  (idle_out)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       i;
        logic       a;
    } exp_t;

    exp_t q[$];
    exp_t held = '0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en  = 1'b0;
    logic reset_q = 1'b0;

    always @(posedge clk_32f) reset_q <= reset;

    task automatic chk(input string name, input exp_t act, input exp_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got v=%0b d=%02h i=%0b a=%0b, want v=%0b d=%02h i=%0b a=%0b",
                     name, $time, act.v, act.d, act.i, act.a, exp.v, exp.d, exp.i, exp.a);
        end
    endtask

    // Monitor: pops an expected entry on each byte strobe, checks held levels otherwise.
    always @(negedge clk_32f) begin
        exp_t act;
        exp_t e;
        if (mon_en) begin
            act = '{v: valid_out, d: data_out, i: idle_out, a: active};
            if (reset_q) begin
                chk("reset_outputs", act, '0);
                n_cmp++;
                if (byte_stb !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_stb @%0t: got byte_stb=%0b want 0", $time, byte_stb);
                end
                held = '0;
            end else if (byte_stb === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_stb @%0t: got byte_stb=1 want 0", $time);
                end else begin
                    e = q.pop_front();
                    chk("byte_boundary", act, e);
                    held = e;
                end
            end else begin
                chk("held_levels", act, held);
            end
        end
    end

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    // exp_stb: this byte ends on an aligned boundary; e is the levels after it
    task automatic send_byte(input logic [7:0] b, input logic exp_stb, input exp_t e);
        if (exp_stb) q.push_back(e);
        for (int k = 7; k >= 0; k--) send_bit(b[k]);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int k = 0; k < n; k++) begin
            data_in = 1'($urandom);
            @(posedge clk_32f);
            #1;
        end
        reset = 1'b0;
    endtask

    exp_t z    = '0;
    exp_t up   = '{v: 1'b0, d: 8'h00, i: 1'b0, a: 1'b1};

    initial begin
        @(posedge clk_32f);
        #1;
        mon_en = 1'b1;
        do_reset(4);

        // Link-up: no strobe on the first COM (found by the search)
        send_byte(8'hBC, 1'b0, z);
        send_byte(8'hBC, 1'b1, z);
        send_byte(8'hBC, 1'b1, z);
        send_byte(8'hBC, 1'b1, up);

        // Data bytes
        send_byte(8'hFF, 1'b1, '{v: 1'b1, d: 8'hFF, i: 1'b0, a: 1'b1});
        send_byte(8'hEE, 1'b1, '{v: 1'b1, d: 8'hEE, i: 1'b0, a: 1'b1});
        send_byte(8'hDD, 1'b1, '{v: 1'b1, d: 8'hDD, i: 1'b0, a: 1'b1});
        send_byte(8'hCC, 1'b1, '{v: 1'b1, d: 8'hCC, i: 1'b0, a: 1'b1});

        // Idle keeps the last data byte; COM in ACTIVE is not data
        send_byte(8'h7C, 1'b1, '{v: 1'b0, d: 8'hCC, i: 1'b1, a: 1'b1});
        send_byte(8'h7C, 1'b1, '{v: 1'b0, d: 8'hCC, i: 1'b1, a: 1'b1});
        send_byte(8'h77, 1'b1, '{v: 1'b1, d: 8'h77, i: 1'b0, a: 1'b1});
        send_byte(8'hBC, 1'b1, '{v: 1'b0, d: 8'h77, i: 1'b0, a: 1'b1});

        // Alignment abort after a fresh reset
        do_reset(2);
        for (int k = 0; k < 3; k++) send_bit(1'($urandom));
        send_byte(8'hBC, 1'b0, z);
        send_byte(8'hBC, 1'b1, z);
        send_byte(8'h55, 1'b1, z);
        send_byte(8'hBC, 1'b0, z);
        send_byte(8'hBC, 1'b1, z);
        send_byte(8'hBC, 1'b1, z);
        send_byte(8'hBC, 1'b1, up);
        send_byte(8'h3A, 1'b1, '{v: 1'b1, d: 8'h3A, i: 1'b0, a: 1'b1});

        // Reset at bit 3 of a data byte
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        do_reset(1);
        send_byte(8'hBC, 1'b0, z);
        send_byte(8'hBC, 1'b1, z);
        send_byte(8'hBC, 1'b1, z);
        send_byte(8'hBC, 1'b1, up);
        send_byte(8'h12, 1'b1, '{v: 1'b1, d: 8'h12, i: 1'b0, a: 1'b1});
        send_byte(8'h7C, 1'b1, '{v: 1'b0, d: 8'h12, i: 1'b1, a: 1'b1});

        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk_32f);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_stb: got %0d outstanding boundaries, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
